lut4_bank_loader: RTL and testbench

//  Runtime programmer and evaluator for a bank of soft LUT4 cells. Accepts 16-bit LUT_INIT

---
 rtl/lut4_cfg_pkg.sv | 19 +
 rtl/lut4_cell.sv | 32 +++
 rtl/lut4_bank_loader.sv | 148 ++++++++++++++
 tb/tb_lut4_bank_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/lut4_cfg_pkg.sv
// Shared types and constants for the LUT4 bank loader.
// Optional readback of committed INIT words is enabled by LUT4_BANK_READBACK_EN.
package lut4_cfg_pkg;

  localparam int LUT_INIT_W = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } lut4_state_e;

  localparam logic [LUT_INIT_W-1:0] INIT_ZERO   = 16'h0000;
  localparam logic [LUT_INIT_W-1:0] INIT_ONE    = 16'hFFFF;
  localparam logic [LUT_INIT_W-1:0] INIT_BUF_I0 = 16'hAAAA;
  localparam logic [LUT_INIT_W-1:0] INIT_NOT_I0 = 16'h5555;

endpackage

// File: rtl/lut4_cell.sv
// One soft LUT4: INIT register with write enable, 16:1 select, registered output.
module lut4_cell
  import lut4_cfg_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [LUT_INIT_W-1:0] init_d,
  input  logic [3:0]            lut_in,
  output logic [LUT_INIT_W-1:0] init,
  output logic                  lut_out
);

  // Live INIT word; only the single COMMIT cycle of a load targeting this cell writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init <= INIT_ZERO;
    end else if (we) begin
      init <= init_d;
    end
  end

  // Registered evaluation; reads the INIT value held before any same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lut_out <= 1'b0;
    end else begin
      lut_out <= init[lut_in];
    end
  end

endmodule

// File: rtl/lut4_bank_loader.sv
// Serial loader and evaluator for a bank of LUT4 cells.
// Config words are shifted MSB first into a shadow register and committed atomically.
// Defining LUT4_BANK_READBACK_EN adds the rd_idx/rd_init readback port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | cfg_ready=1, waiting for a config word
// SHIFT  | 16 cycles, one INIT bit per cycle into the shadow register
// COMMIT | shadow written into the target cell; load_done follows
module lut4_bank_loader
  import lut4_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 16,
  parameter int IDX_W    = $clog2(NUM_LUTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [LUT_INIT_W-1:0] cfg_init,
  output logic                  busy,
  output logic                  load_done,
  output logic                  cfg_err,
  input  logic [4*NUM_LUTS-1:0] lut_in,
  output logic [NUM_LUTS-1:0]   lut_out
`ifdef LUT4_BANK_READBACK_EN
  ,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [LUT_INIT_W-1:0] rd_init
`endif
);

  lut4_state_e           state_q;
  lut4_state_e           state_d;
  logic [LUT_INIT_W-1:0] word_q;
  logic [LUT_INIT_W-1:0] shadow_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  accept;
  logic                  idx_ok;
  logic [NUM_LUTS-1:0]   cell_we;
  logic [LUT_INIT_W-1:0] cell_init [NUM_LUTS];

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = cfg_valid && cfg_ready;
  // IDX_W may be wider than needed, so range is checked explicitly.
  assign idx_ok    = (32'(cfg_idx) < NUM_LUTS);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a bad index is rejected without leaving IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && idx_ok) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture on accept, then serial shift MSB first while the counter runs 15..0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q   <= INIT_ZERO;
      shadow_q <= INIT_ZERO;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else if (accept && idx_ok) begin
      word_q <= cfg_init;
      idx_q  <= cfg_idx;
      cnt_q  <= '1;
    end else if (state_q == SHIFT) begin
      shadow_q <= {shadow_q[LUT_INIT_W-2:0], word_q[cnt_q]};
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  // Status pulses; load_done rises together with the newly written INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_done <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      load_done <= (state_q == COMMIT);
      cfg_err   <= accept && !idx_ok;
    end
  end

  for (genvar i = 0; i < NUM_LUTS; i++) begin : g_cell
    assign cell_we[i] = (state_q == COMMIT) && (32'(idx_q) == i);

    lut4_cell u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (cell_we[i]),
      .init_d  (shadow_q),
      .lut_in  (lut_in[4*i +: 4]),
      .init    (cell_init[i]),
      .lut_out (lut_out[i])
    );
  end

`ifdef LUT4_BANK_READBACK_EN
  logic [LUT_INIT_W-1:0] rd_sel;

  // Readback select; indices past the bank read as zero.
  always_comb begin
    rd_sel = INIT_ZERO;
    for (int i = 0; i < NUM_LUTS; i++) begin
      if (32'(rd_idx) == i) begin
        rd_sel = cell_init[i];
      end
    end
  end

  // Registered readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_init <= INIT_ZERO;
    end else begin
      rd_init <= rd_sel;
    end
  end
`endif

endmodule

// File: tb/tb_lut4_bank_loader.sv
// Directed, self-checking bench for lut4_bank_loader with a lut_out scoreboard.
// Readback steps run only when LUT4_BANK_READBACK_EN is defined.
module tb_lut4_bank_loader;
  import lut4_cfg_pkg::*;

  localparam int NUM_LUTS = 16;
  localparam int IDX_W    = 5;

  logic                  clk       = 1'b0;
  logic                  rst_n     = 1'b0;
  logic                  cfg_valid = 1'b0;
  logic [IDX_W-1:0]      cfg_idx   = '0;
  logic [15:0]           cfg_init  = '0;
  logic [4*NUM_LUTS-1:0] lut_in    = '0;
  logic                  cfg_ready;
  logic                  busy;
  logic                  load_done;
  logic                  cfg_err;
  logic [NUM_LUTS-1:0]   lut_out;
`ifdef LUT4_BANK_READBACK_EN
  logic [IDX_W-1:0]      rd_idx = '0;
  logic [15:0]           rd_init;
`endif

  always #5 clk = ~clk;

  lut4_bank_loader #(.NUM_LUTS(NUM_LUTS), .IDX_W(IDX_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_idx   (cfg_idx),
    .cfg_init  (cfg_init),
    .busy      (busy),
    .load_done (load_done),
    .cfg_err   (cfg_err),
    .lut_in    (lut_in),
    .lut_out   (lut_out)
`ifdef LUT4_BANK_READBACK_EN
    ,
    .rd_idx    (rd_idx),
    .rd_init   (rd_init)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] m_init [NUM_LUTS];

  typedef struct {
    string               tag;
    logic [NUM_LUTS-1:0] exp;
  } sb_t;
  sb_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_LUTS-1:0] model_out(input logic [4*NUM_LUTS-1:0] li);
    logic [NUM_LUTS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_LUTS; i++) begin
      r[i] = m_init[i][li[4*i +: 4]];
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic eval_cycle(input string tag);
    sb_t e;
    sb.push_back('{tag, model_out(lut_in)});
    step();
    e = sb.pop_front();
    chk(e.tag, 32'(lut_out), 32'(e.exp));
  endtask

  task automatic do_load(input int idx, input logic [15:0] val, input string tag);
    int lat;
    chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b1;
    cfg_idx   = IDX_W'(idx);
    cfg_init  = val;
    eval_cycle({tag, "_acc"});
    cfg_valid = 1'b0;
    cfg_init  = ~val;
    cfg_idx   = IDX_W'(idx + 1);
    chk({tag, "_busy"}, 32'({busy, cfg_ready}), 32'd2);
    lat = 0;
    while (load_done !== 1'b1 && lat < 40) begin
      lut_in = {$urandom, $urandom};
      eval_cycle({tag, "_hold"});
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd17);
    chk({tag, "_idle"}, 32'({busy, cfg_ready}), 32'd1);
    m_init[idx] = val;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_done;
    for (int i = 0; i < NUM_LUTS; i++) m_init[i] = INIT_ZERO;

    // Reset state
    lut_in = {$urandom, $urandom};
    step();
    chk("rst_out", 32'(lut_out), 32'd0);
    chk("rst_ready_busy", 32'({cfg_ready, busy}), 32'd2);
    chk("rst_pulses", 32'({load_done, cfg_err}), 32'd0);
    step();
    rst_n = 1'b1;

    // 1: any input gives zero
    for (int k = 0; k < 4; k++) begin
      lut_in = {$urandom, $urandom};
      eval_cycle("t1_out");
    end

    // 2: buffer I0 in cell 3
    lut_in = {$urandom, $urandom};
    do_load(3, INIT_BUF_I0, "t2");
    for (int s = 0; s < 16; s++) begin
      lut_in = {$urandom, $urandom};
      lut_in[15:12] = 4'(s);
      eval_cycle("t2_sweep");
      chk("t2_i0", 32'(lut_out[3]), 32'(s & 1));
    end

    // 3: inverter then 8001 on cell 0, inputs tied together
    do_load(0, INIT_NOT_I0, "t3a");
    for (int a = 0; a < 2; a++) begin
      lut_in = {$urandom, $urandom};
      lut_in[3:0] = {4{a[0]}};
      eval_cycle("t3a_eval");
      chk("t3a_inv", 32'(lut_out[0]), 32'(1 - a));
    end
    do_load(0, 16'h8001, "t3b");
    for (int a = 0; a < 2; a++) begin
      lut_in = {$urandom, $urandom};
      lut_in[3:0] = {4{a[0]}};
      eval_cycle("t3b_eval");
      chk("t3b_one", 32'(lut_out[0]), 32'd1);
    end

    // Reload same cell and value: timing identical, no glitch (hold checks every cycle)
    lut_in = '1;
    do_load(3, INIT_BUF_I0, "reload");

    // 4: out-of-range index
    cfg_valid = 1'b1;
    cfg_idx   = 5'd20;
    cfg_init  = INIT_ONE;
    lut_in    = '1;
    eval_cycle("t4_acc");
    cfg_valid = 1'b0;
    chk("t4_err", 32'(cfg_err), 32'd1);
    chk("t4_ready_busy", 32'({cfg_ready, busy}), 32'd2);
    eval_cycle("t4_after");
    chk("t4_err_clr", 32'(cfg_err), 32'd0);
    for (int k = 0; k < 20; k++) begin
      eval_cycle("t4_nochange");
      chk("t4_idle", 32'(busy), 32'd0);
    end

    // 5: reset in the middle of SHIFT
    lut_in    = '1;
    cfg_valid = 1'b1;
    cfg_idx   = 5'd7;
    cfg_init  = INIT_ONE;
    step();
    cfg_valid = 1'b0;
    repeat (8) step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NUM_LUTS; i++) m_init[i] = INIT_ZERO;
    chk("t5_rst_out", 32'(lut_out), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    step();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int k = 0; k < 24; k++) begin
      eval_cycle("t5_out");
      if (load_done === 1'b1) seen_done = 1'b1;
    end
    chk("t5_no_done", 32'(seen_done), 32'd0);
    chk("t5_ready", 32'(cfg_ready), 32'd1);

`ifdef LUT4_BANK_READBACK_EN
    // 6: readback
    rd_idx = 5'd5;
    do_load(5, 16'h1234, "t6");
    chk("t6_rd_commit", 32'(rd_init), 32'd0);
    eval_cycle("t6_eval");
    chk("t6_rd", 32'(rd_init), 32'h1234);
    rd_idx = 5'd20;
    eval_cycle("t6_eval_oor");
    chk("t6_rd_oor", 32'(rd_init), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
